// File: rtl/pipeline_writeback_if.sv
// Signal bundle between the MEM stage / D-stage reader (master) and the
// writeback stage (slave): M-stage sideband, W-stage data, register-file read ports.
interface pipeline_writeback_if #(
  parameter int XLEN = 32
);
  logic [4:0]      rdM;
  logic [3:0]      memOpTypeM;
  logic [1:0]      addrLsbM;
  logic [XLEN-1:0] pcPlus4M;
  logic            regWriteEnW;
  logic [1:0]      resultSrcW;
  logic [XLEN-1:0] aluResultW;
  logic [XLEN-1:0] memReadDataW;
  logic [4:0]      rs1AddrD;
  logic [4:0]      rs2AddrD;
  logic [XLEN-1:0] rs1DataD;
  logic [XLEN-1:0] rs2DataD;
  logic [XLEN-1:0] resultW;
  logic [4:0]      rdW;
  logic            wbValidW;

  modport master (
    output rdM, memOpTypeM, addrLsbM, pcPlus4M,
    output regWriteEnW, resultSrcW, aluResultW, memReadDataW,
    output rs1AddrD, rs2AddrD,
    input  rs1DataD, rs2DataD, resultW, rdW, wbValidW
  );

  modport slave (
    input  rdM, memOpTypeM, addrLsbM, pcPlus4M,
    input  regWriteEnW, resultSrcW, aluResultW, memReadDataW,
    input  rs1AddrD, rs2AddrD,
    output rs1DataD, rs2DataD, resultW, rdW, wbValidW
  );
endinterface

// File: rtl/pipeline_writeback.sv
// W stage: realigns M-stage sideband with the D-SRAM read data, formats loads,
// selects the writeback value and owns the integer register file with bypass.
module pipeline_writeback #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input logic              clk,
  input logic              resetn,
  pipeline_writeback_if.slave wb
);

  localparam logic [3:0] NO_MEM  = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;

  logic [4:0]      rd_q;
  logic [3:0]      mem_op_q;
  logic [1:0]      addr_lsb_q;
  logic [XLEN-1:0] pc_plus4_q;

  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] result;
  logic            wb_valid;

  logic [XLEN-1:0] regs [NREGS];

  // Sideband captured here so it lines up with the 1-cycle D-SRAM read latency.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      rd_q       <= '0;
      mem_op_q   <= NO_MEM;
      addr_lsb_q <= '0;
      pc_plus4_q <= '0;
    end else begin
      rd_q       <= wb.rdM;
      mem_op_q   <= wb.memOpTypeM;
      addr_lsb_q <= wb.addrLsbM;
      pc_plus4_q <= wb.pcPlus4M;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    byte_sel  = wb.memReadDataW[7:0];
    half_sel  = addr_lsb_q[1] ? wb.memReadDataW[31:16] : wb.memReadDataW[15:0];
    load_data = wb.memReadDataW;
    case (addr_lsb_q)
      2'd1:    byte_sel = wb.memReadDataW[15:8];
      2'd2:    byte_sel = wb.memReadDataW[23:16];
      2'd3:    byte_sel = wb.memReadDataW[31:24];
      default: byte_sel = wb.memReadDataW[7:0];
    endcase
    // Word loads arrive already aligned, so the offset is irrelevant for LW.
    case (mem_op_q)
      MEM_LB:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      MEM_LBU: load_data = {{(XLEN-8){1'b0}}, byte_sel};
      MEM_LH:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
      MEM_LHU: load_data = {{(XLEN-16){1'b0}}, half_sel};
      MEM_LW:  load_data = wb.memReadDataW;
      default: load_data = wb.memReadDataW;
    endcase
  end

  always_comb begin
    result = '0;
    case (wb.resultSrcW)
      2'b00:   result = wb.aluResultW;
      2'b01:   result = load_data;
      2'b10:   result = pc_plus4_q;
      default: result = '0;
    endcase
  end

  assign wb_valid = wb.regWriteEnW && (rd_q != 5'd0);

  // NOTE: the register file is deliberately reset entry by entry; the core
  // relies on all architectural registers reading zero after reset.
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid) begin
      regs[rd_q] <= result;
    end
  end

  // Write-through bypass lets the D stage see this cycle's writeback.
  assign wb.rs1DataD = (wb.rs1AddrD == 5'd0)                  ? '0     :
                       (wb_valid && (wb.rs1AddrD == rd_q))     ? result :
                                                                 regs[wb.rs1AddrD];
  assign wb.rs2DataD = (wb.rs2AddrD == 5'd0)                  ? '0     :
                       (wb_valid && (wb.rs2AddrD == rd_q))     ? result :
                                                                 regs[wb.rs2AddrD];

  assign wb.resultW  = result;
  assign wb.rdW      = rd_q;
  assign wb.wbValidW = wb_valid;

endmodule

// File: tb/tb_pipeline_writeback.sv
// Bench for pipeline_writeback: load-format vector table, hand-written
// reset/bypass/x0/link sequences, then random pipelined traffic against a model.
module tb_pipeline_writeback;

  localparam logic [3:0] NO_MEM  = 4'd0;
  localparam logic [3:0] MEM_LB  = 4'd1;
  localparam logic [3:0] MEM_LH  = 4'd2;
  localparam logic [3:0] MEM_LW  = 4'd3;
  localparam logic [3:0] MEM_LBU = 4'd4;
  localparam logic [3:0] MEM_LHU = 4'd5;
  localparam logic [3:0] MEM_SW  = 4'd8;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [1:0]  lsb;
    logic [31:0] mem;
    logic [31:0] exp;
  } load_vec_t;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  pipeline_writeback_if #(.XLEN(32)) bus ();

  pipeline_writeback #(.XLEN(32), .NREGS(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .wb     (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  // Architectural state as the bench believes it, plus the M-stage fields
  // the bench issued one edge ago.
  logic [31:0] model [32];
  logic [4:0]  p_rd;
  logic [3:0]  p_op;
  logic [1:0]  p_lsb;
  logic [31:0] p_pc4;

  load_vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [3:0] op, input logic [1:0] lsb,
                                           input logic [31:0] d);
    logic [31:0] b;
    logic [31:0] h;
    b = d >> (8 * int'(lsb));
    h = d >> (16 * int'(lsb[1]));
    case (op)
      MEM_LB:  return {{24{b[7]}}, b[7:0]};
      MEM_LBU: return {24'd0, b[7:0]};
      MEM_LH:  return {{16{h[15]}}, h[15:0]};
      MEM_LHU: return {16'd0, h[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ref_result();
    case (bus.resultSrcW)
      2'b00:   return bus.aluResultW;
      2'b01:   return ref_load(p_op, p_lsb, bus.memReadDataW);
      2'b10:   return p_pc4;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_valid();
    return bus.regWriteEnW && (p_rd != 5'd0);
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (ref_valid() && a == p_rd) return ref_result();
    return model[a];
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".resultW"},  bus.resultW, ref_result());
    check({tag, ".rdW"},      {27'd0, bus.rdW}, {27'd0, p_rd});
    check({tag, ".wbValidW"}, {31'd0, bus.wbValidW}, {31'd0, ref_valid()});
    check({tag, ".rs1DataD"}, bus.rs1DataD, ref_read(bus.rs1AddrD));
    check({tag, ".rs2DataD"}, bus.rs2DataD, ref_read(bus.rs2AddrD));
  endtask

  task automatic drive_m(input logic [4:0] rd, input logic [3:0] op,
                         input logic [1:0] lsb, input logic [31:0] pc4);
    bus.rdM        = rd;
    bus.memOpTypeM = op;
    bus.addrLsbM   = lsb;
    bus.pcPlus4M   = pc4;
  endtask

  task automatic drive_w(input logic we, input logic [1:0] src,
                         input logic [31:0] alu, input logic [31:0] mem);
    bus.regWriteEnW  = we;
    bus.resultSrcW   = src;
    bus.aluResultW   = alu;
    bus.memReadDataW = mem;
  endtask

  task automatic set_rd(input logic [4:0] a1, input logic [4:0] a2);
    bus.rs1AddrD = a1;
    bus.rs2AddrD = a2;
  endtask

  // Commit the pending writeback into the model, clock once, record new M fields.
  task automatic step();
    logic [31:0] r;
    r = ref_result();
    if (ref_valid()) model[p_rd] = r;
    @(posedge clk);
    p_rd  = bus.rdM;
    p_op  = bus.memOpTypeM;
    p_lsb = bus.addrLsbM;
    p_pc4 = bus.pcPlus4M;
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    p_rd  = 5'd0;
    p_op  = NO_MEM;
    p_lsb = 2'd0;
    p_pc4 = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{"lb_off3",  MEM_LB,  2'd3, 32'h80FF_7F01, 32'hFFFF_FF80};
    vecs[1]  = '{"lbu_off3", MEM_LBU, 2'd3, 32'h80FF_7F01, 32'h0000_0080};
    vecs[2]  = '{"lb_off1",  MEM_LB,  2'd1, 32'h80FF_7F01, 32'h0000_007F};
    vecs[3]  = '{"lb_off2",  MEM_LB,  2'd2, 32'h80FF_7F01, 32'hFFFF_FFFF};
    vecs[4]  = '{"lbu_off0", MEM_LBU, 2'd0, 32'h80FF_7F01, 32'h0000_0001};
    vecs[5]  = '{"lh_off2",  MEM_LH,  2'd2, 32'h8001_7FFE, 32'hFFFF_8001};
    vecs[6]  = '{"lhu_off2", MEM_LHU, 2'd2, 32'h8001_7FFE, 32'h0000_8001};
    vecs[7]  = '{"lh_off0",  MEM_LH,  2'd0, 32'h8001_7FFE, 32'h0000_7FFE};
    vecs[8]  = '{"lw_off0",  MEM_LW,  2'd0, 32'h8001_7FFE, 32'h8001_7FFE};
    vecs[9]  = '{"lw_off3",  MEM_LW,  2'd3, 32'h8001_7FFE, 32'h8001_7FFE};
    vecs[10] = '{"lhu_off3", MEM_LHU, 2'd3, 32'h8001_7FFE, 32'h0000_8001};
    vecs[11] = '{"sw_raw",   MEM_SW,  2'd1, 32'h8001_7FFE, 32'h8001_7FFE};

    // Power-on reset
    drive_m(5'd0, NO_MEM, 2'd0, 32'd0);
    drive_w(1'b0, 2'b00, 32'd0, 32'd0);
    set_rd(5'd0, 5'd0);
    clear_model();
    resetn = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check_all("por");

    // Reset arriving while a write to x5 is in flight
    drive_m(5'd5, NO_MEM, 2'd0, 32'd0);
    step();
    drive_m(5'd0, NO_MEM, 2'd0, 32'd0);
    drive_w(1'b1, 2'b00, 32'hAAAA_5555, 32'd0);
    set_rd(5'd5, 5'd5);
    #1;
    check_all("pre_rst");
    resetn = 1'b1;
    #1;
    clear_model();
    check_all("mid_rst");
    @(posedge clk);
    #1;
    resetn = 1'b0;
    drive_w(1'b0, 2'b00, 32'd0, 32'd0);
    #1;
    check("rst.reg5", bus.rs1DataD, 32'd0);
    check_all("post_rst");

    // ALU writeback with same-cycle bypass, then from the array
    drive_m(5'd3, NO_MEM, 2'd0, 32'd0);
    step();
    drive_m(5'd0, NO_MEM, 2'd0, 32'd0);
    drive_w(1'b1, 2'b00, 32'h1234_5678, 32'd0);
    set_rd(5'd3, 5'd0);
    #1;
    check("alu.bypass", bus.rs1DataD, 32'h1234_5678);
    check_all("alu_w");
    step();
    drive_w(1'b0, 2'b00, 32'd0, 32'd0);
    #1;
    check("alu.array", bus.rs1DataD, 32'h1234_5678);
    check_all("alu_r");

    // Load formatting table
    for (int i = 0; i < 12; i++) begin
      drive_m(5'd7, vecs[i].op, vecs[i].lsb, 32'd0);
      drive_w(1'b0, 2'b00, 32'd0, 32'd0);
      step();
      drive_m(5'd0, NO_MEM, 2'd0, 32'd0);
      drive_w(1'b1, 2'b01, 32'h0BAD_0BAD, vecs[i].mem);
      set_rd(5'd7, 5'd3);
      #1;
      check(vecs[i].name, bus.resultW, vecs[i].exp);
      check({vecs[i].name, ".rs1"}, bus.rs1DataD, vecs[i].exp);
      check_all(vecs[i].name);
      step();
    end
    drive_w(1'b0, 2'b00, 32'd0, 32'd0);

    // x0 stays zero
    drive_m(5'd0, NO_MEM, 2'd0, 32'd0);
    step();
    drive_w(1'b1, 2'b00, 32'hDEAD_BEEF, 32'd0);
    set_rd(5'd0, 5'd0);
    #1;
    check("x0.rs1", bus.rs1DataD, 32'd0);
    check("x0.rs2", bus.rs2DataD, 32'd0);
    check("x0.valid", {31'd0, bus.wbValidW}, 32'd0);
    check("x0.result", bus.resultW, 32'hDEAD_BEEF);
    step();
    drive_w(1'b0, 2'b00, 32'd0, 32'd0);

    // Reserved result select writes zero
    drive_m(5'd9, MEM_LW, 2'd0, 32'h0000_0055);
    step();
    drive_m(5'd0, NO_MEM, 2'd0, 32'd0);
    drive_w(1'b1, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    set_rd(5'd9, 5'd9);
    #1;
    check("rsv.result", bus.resultW, 32'd0);
    step();
    drive_w(1'b0, 2'b00, 32'd0, 32'd0);
    #1;
    check("rsv.reg9", bus.rs2DataD, 32'd0);

    // JAL link followed immediately by an ALU write to the same register
    drive_m(5'd1, NO_MEM, 2'd0, 32'h0000_0104);
    step();
    drive_m(5'd1, NO_MEM, 2'd0, 32'd0);
    drive_w(1'b1, 2'b10, 32'hFFFF_0000, 32'd0);
    set_rd(5'd2, 5'd1);
    #1;
    check("jal.bypass", bus.rs2DataD, 32'h0000_0104);
    check_all("jal");
    step();
    drive_m(5'd0, NO_MEM, 2'd0, 32'd0);
    drive_w(1'b1, 2'b00, 32'h0000_0007, 32'd0);
    #1;
    check("b2b.bypass", bus.rs2DataD, 32'h0000_0007);
    check_all("b2b");
    step();
    drive_w(1'b0, 2'b00, 32'd0, 32'd0);
    #1;
    check("b2b.array", bus.rs2DataD, 32'h0000_0007);

    // Random pipelined traffic
    for (int n = 0; n < 400; n++) begin
      drive_w(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
      drive_m(5'($urandom_range(0, 31)), 4'($urandom_range(0, 11)),
              2'($urandom_range(0, 3)), $urandom);
      set_rd(($urandom_range(0, 2) == 0) ? p_rd : 5'($urandom_range(0, 31)),
             ($urandom_range(0, 2) == 0) ? p_rd : 5'($urandom_range(0, 31)));
      #1;
      check_all("rnd");
      step();
    end

    // Final sweep of the array with no writeback pending
    drive_w(1'b0, 2'b00, 32'd0, 32'd0);
    drive_m(5'd0, NO_MEM, 2'd0, 32'd0);
    step();
    for (int i = 0; i < 32; i++) begin
      set_rd(5'(i), 5'(31 - i));
      #1;
      check_all("sweep");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
